// File: rtl/uart_tx_drain_pkg.sv
// rtl/uart_tx_drain_pkg.sv - shared UART state encodings and constants
package uart_tx_drain_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, pulses bit_end when count reaches div_q
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (load) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_end = (cnt_q == div_q);

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - 8N1/8N2 UART transmitter draining a first-word-fall-through fifo
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int DIV_WIDTH = UART_DIV_WIDTH,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_r,
  output logic                 tx,
  output logic                 busy
);

  // Any STOP_BITS value other than 2 behaves as a single stop bit.
  localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end, baud_load, frame_end, pop;

  uart_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (baud_load),
    .div_q   (div_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    div_d     = div_q;
    frame_end = 1'b0;

    case (state_q)
      UART_START: begin
        if (bit_end) begin
          state_d = UART_DATA;
          idx_d   = 3'd0;
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            state_d = UART_STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            frame_end = 1'b1;
            state_d   = UART_IDLE;
            idx_d     = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: ;
    endcase

    // A pop at frame end overrides the return to IDLE so frames run back to back.
    pop = !rst && !fifo_empty && ((state_q == UART_IDLE) || frame_end);
    if (pop) begin
      shift_d = fifo_dout;
      div_d   = div;
      state_d = UART_START;
      idx_d   = 3'd0;
    end

    baud_load = (state_q == UART_IDLE) || bit_end;

    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
    busy_d = (state_d != UART_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_r = pop;
  assign tx     = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - randomized check of uart_tx_drain (1 and 2 stop bits) against a line model
module tb_uart_tx_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = 16'd0;
  logic [7:0]  dout0 = 8'h00, dout1 = 8'h00;
  logic        empty0 = 1'b1, empty1 = 1'b1;
  logic        r0, r1, tx0, tx1, busy0, busy1;

  byte unsigned fq0[$], fq1[$];
  bit           eq0[$], eq1[$];
  int           n_checks = 0;
  int           n_pass = 0;
  bit           armed = 1'b0;

  always #5 clk = ~clk;

  uart_tx_drain #(.DIV_WIDTH(16), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .div(div), .fifo_dout(dout0), .fifo_empty(empty0),
    .fifo_r(r0), .tx(tx0), .busy(busy0)
  );

  uart_tx_drain #(.DIV_WIDTH(16), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .div(div), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_r(r1), .tx(tx1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line is a queue of per-cycle tx values; a frame is appended when a pop is due.
  task automatic model_unit(input int u, input logic txv, input logic busyv, input logic rv,
                            input logic emptyv, input byte unsigned head, output bit pop);
    bit line[$];
    bit exp_tx, exp_busy, exp_pop, v;
    int s;
    if (u == 0) begin line = eq0; s = 1; end
    else        begin line = eq1; s = 2; end
    exp_busy = (line.size() > 0);
    exp_tx   = 1'b1;
    if (exp_busy) exp_tx = line.pop_front();
    exp_pop = !rst && !emptyv && (line.size() == 0);
    check($sformatf("tx%0d", u), {31'd0, txv}, {31'd0, exp_tx});
    check($sformatf("busy%0d", u), {31'd0, busyv}, {31'd0, exp_busy});
    check($sformatf("fifo_r%0d", u), {31'd0, rv}, {31'd0, exp_pop});
    if (exp_pop) begin
      for (int i = 0; i < 9 + s; i++) begin
        if (i == 0)      v = 1'b0;
        else if (i <= 8) v = head[i-1];
        else             v = 1'b1;
        repeat (int'(div) + 1) line.push_back(v);
      end
    end
    if (rst) line.delete();
    if (u == 0) eq0 = line;
    else        eq1 = line;
    pop = rv;
  endtask

  task automatic update_fifo();
    empty0 = (fq0.size() == 0);
    dout0  = empty0 ? 8'h00 : fq0[0];
    empty1 = (fq1.size() == 0);
    dout1  = empty1 ? 8'h00 : fq1[0];
  endtask

  task automatic push(input byte unsigned b);
    fq0.push_back(b);
    fq1.push_back(b);
    update_fifo();
  endtask

  task automatic step();
    bit p0, p1;
    p0 = 1'b0;
    p1 = 1'b0;
    @(negedge clk);
    if (armed) begin
      model_unit(0, tx0, busy0, r0, empty0, dout0, p0);
      model_unit(1, tx1, busy1, r1, empty1, dout1, p1);
    end
    @(posedge clk);
    #1;
    if (p0 && fq0.size() > 0) void'(fq0.pop_front());
    if (p1 && fq1.size() > 0) void'(fq1.pop_front());
    update_fifo();
  endtask

  initial begin
    @(posedge clk);
    #1;
    armed = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (50) step();

    div = 16'd3;
    push(8'hA5);
    repeat (60) step();

    div = 16'd0;
    push(8'h00); push(8'hFF); push(8'h55);
    repeat (45) step();

    div = 16'd1;
    push(8'h80);
    repeat (30) step();

    div = 16'd7;
    push(8'h5A); push(8'hC3);
    repeat (30) step();
    div = 16'd1;
    repeat (200) step();

    push(8'h3C); push(8'h11); push(8'h22);
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (80) step();

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0 && fq0.size() < 8) push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 99) == 0) div = 16'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    repeat (400) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
